// File: rtl/pc_unit_param.sv
// pc_unit_param: program counter for the single-cycle MIPS datapath.
// Holds the current instruction address and selects the next one from
// sequential, branch, jump and return sources, with stall support.
// Optional return-address stack enabled by defining PC_RAS_EN; without it
// sel=11 behaves as a plain register jump and the stack flags are tied off.
module pc_unit_param #(
  parameter int WIDTH     = 8,
  parameter int STEP      = 1,
  parameter int RESET_VEC = 0,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] branch_off,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             call,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_err
);

  // Pointer indexes RAS_DEPTH entries; count needs one extra bit for "full".
  localparam int unsigned PW = (RAS_DEPTH > 2) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    SEL_SEQ = 2'b00,
    SEL_BR  = 2'b01,
    SEL_JMP = 2'b10,
    SEL_RET = 2'b11
  } sel_e;

  sel_e             sel_q;
  logic [WIDTH-1:0] pc_next;

  assign sel_q   = sel_e'(sel);
  assign pc_plus = pc + WIDTH'(STEP);

`ifdef PC_RAS_EN
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]    wptr;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] ras_top;
  logic             push;
  logic             pop;
  logic             underflow;

  assign ras_empty = (count == '0);
  assign ras_full  = (count == CW'(RAS_DEPTH));
  assign ras_top   = ras_mem[wptr - 1'b1];

  // Next-PC selection and stack push/pop decode.
  always_comb begin
    pc_next   = pc_plus;
    push      = 1'b0;
    pop       = 1'b0;
    underflow = 1'b0;
    case (sel_q)
      SEL_SEQ: pc_next = pc_plus;
      SEL_BR:  pc_next = pc_plus + branch_off;
      SEL_JMP: begin
        pc_next = jump_target;
        push    = call;
      end
      SEL_RET: begin
        if (ras_empty) begin
          underflow = 1'b1;
        end else begin
          pc_next = ras_top;
          pop     = 1'b1;
        end
      end
      default: pc_next = pc_plus;
    endcase
  end

  // PC, stack pointer, occupancy and sticky error register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= WIDTH'(RESET_VEC);
      wptr    <= '0;
      count   <= '0;
      ras_err <= 1'b0;
    end else if (!stall) begin
      pc <= pc_next;
      if (push) begin
        // Circular write: when full, wptr already points at the oldest entry.
        wptr <= wptr + 1'b1;
        if (ras_full) ras_err <= 1'b1;
        else          count   <= count + 1'b1;
      end else if (pop) begin
        wptr  <= wptr - 1'b1;
        count <= count - 1'b1;
      end
      if (underflow) ras_err <= 1'b1;
    end
  end

  // Stack storage; contents are meaningless while count is zero, so no reset.
  always_ff @(posedge clk) begin
    if (!rst && !stall && push) ras_mem[wptr] <= pc_plus;
  end
`else
  logic          unused_call;
  logic [CW-1:0] unused_depth;

  assign unused_call  = call;
  assign unused_depth = '0;
  assign ras_empty    = 1'b1;
  assign ras_full     = 1'b0;
  assign ras_err      = 1'b0;

  // Next-PC selection; return is a plain register jump.
  always_comb begin
    pc_next = pc_plus;
    case (sel_q)
      SEL_SEQ: pc_next = pc_plus;
      SEL_BR:  pc_next = pc_plus + branch_off;
      SEL_JMP: pc_next = jump_target;
      SEL_RET: pc_next = jump_target;
      default: pc_next = pc_plus;
    endcase
  end

  // PC register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         pc <= WIDTH'(RESET_VEC);
    else if (!stall) pc <= pc_next;
  end
`endif

endmodule

// File: tb/tb_pc_unit_param.sv
// Testbench for pc_unit_param with default parameters. RAS scenarios are
// exercised when PC_RAS_EN is defined, plain-jr behaviour otherwise.
module tb_pc_unit_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       stall;
  logic [1:0] sel;
  logic [7:0] branch_off;
  logic [7:0] jump_target;
  logic       call;
  logic [7:0] pc;
  logic [7:0] pc_plus;
  logic       ras_empty;
  logic       ras_full;
  logic       ras_err;

`ifdef PC_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  // Scoreboard of expected {pc, pc_plus, empty, full, err}.
  logic [18:0] q[$];
  // Reference model state.
  logic [7:0]  mpc;
  logic [7:0]  mstk[$];
  logic        merr;

  pc_unit_param #(.WIDTH(8), .STEP(1), .RESET_VEC(0), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .sel(sel), .branch_off(branch_off),
    .jump_target(jump_target), .call(call), .pc(pc), .pc_plus(pc_plus),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_err(ras_err)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] model_out();
    logic [7:0] pp;
    pp = mpc + 8'd1;
    return {mpc, pp, mstk.size() == 0, mstk.size() == 4, merr};
  endfunction

  task automatic model_reset();
    mpc = 8'h00;
    mstk.delete();
    merr = 1'b0;
  endtask

  // Drive one cycle of stimulus, advance the model, push its prediction.
  task automatic cyc(input logic [1:0] s, input logic [7:0] bo, input logic [7:0] jt,
                     input logic c, input logic st);
    logic [7:0] pp;
    sel = s; branch_off = bo; jump_target = jt; call = c; stall = st;
    pp = mpc + 8'd1;
    if (!st) begin
      case (s)
        2'b00: mpc = pp;
        2'b01: mpc = pp + bo;
        2'b10: begin
          if (RAS && c) begin
            if (mstk.size() == 4) begin
              void'(mstk.pop_front());
              merr = 1'b1;
            end
            mstk.push_back(pp);
          end
          mpc = jt;
        end
        default: begin
          if (!RAS)                  mpc = jt;
          else if (mstk.size() == 0) begin mpc = pp; merr = 1'b1; end
          else                       mpc = mstk.pop_back();
        end
      endcase
    end
    q.push_back(model_out());
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [18:0] got;
    rst = 1'b1; stall = 1'b0; sel = 2'b00; branch_off = '0; jump_target = '0; call = 1'b0;
    model_reset();
    @(posedge clk); #1;
    got = {pc, pc_plus, ras_empty, ras_full, ras_err};
    checks++;
    if (got !== 19'({8'h00, 8'h01, 3'b100})) begin
      $display("FAIL reset: got pc=%h pc_plus=%h efe=%b, expected pc=00 pc_plus=01 efe=100",
               pc, pc_plus, got[2:0]);
      failures++;
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_seq();
    logic [18:0] e;
    logic [18:0] got;
    for (int i = 0; i < 3; i++) begin
      cyc(2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
      e = q.pop_front(); got = {pc, pc_plus, ras_empty, ras_full, ras_err};
      checks++;
      if (got !== e) begin
        $display("FAIL seq step %0d: got pc=%h pc_plus=%h efe=%b, expected pc=%h pc_plus=%h efe=%b",
                 i, pc, pc_plus, got[2:0], e[18:11], e[10:3], e[2:0]);
        failures++;
      end
    end
    checks++;
    if (pc !== 8'h03 || pc_plus !== 8'h04) begin
      $display("FAIL seq_end: got pc=%h pc_plus=%h, expected pc=03 pc_plus=04", pc, pc_plus);
      failures++;
    end
    cyc(2'b10, 8'h00, 8'hFE, 1'b0, 1'b0);
    e = q.pop_front(); checks++;
    if (pc !== e[18:11]) begin
      $display("FAIL jump_fe: got pc=%h, expected %h", pc, e[18:11]);
      failures++;
    end
    for (int i = 0; i < 3; i++) begin
      cyc(2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
      e = q.pop_front(); got = {pc, pc_plus, ras_empty, ras_full, ras_err};
      checks++;
      if (got !== e) begin
        $display("FAIL wrap step %0d: got pc=%h pc_plus=%h, expected pc=%h pc_plus=%h",
                 i, pc, pc_plus, e[18:11], e[10:3]);
        failures++;
      end
    end
    checks++;
    if (pc !== 8'h01) begin
      $display("FAIL wrap_end: got pc=%h, expected 01", pc);
      failures++;
    end
  endtask

  task automatic test_branch_stall();
    logic [18:0] e;
    cyc(2'b10, 8'h00, 8'h10, 1'b0, 1'b0);
    e = q.pop_front();
    cyc(2'b01, 8'hFC, 8'h00, 1'b0, 1'b0);
    e = q.pop_front(); checks++;
    if (pc !== e[18:11] || pc !== 8'h0D) begin
      $display("FAIL branch: got pc=%h, expected %h", pc, e[18:11]);
      failures++;
    end
    for (int i = 0; i < 2; i++) begin
      cyc(2'b10, 8'h00, 8'h80, 1'b1, 1'b1);
      e = q.pop_front(); checks++;
      if ({pc, pc_plus, ras_empty, ras_full, ras_err} !== e) begin
        $display("FAIL stall step %0d: got pc=%h pc_plus=%h empty=%b err=%b, expected pc=%h pc_plus=%h efe=%b",
                 i, pc, pc_plus, ras_empty, ras_err, e[18:11], e[10:3], e[2:0]);
        failures++;
      end
    end
    stall = 1'b0;
  endtask

  task automatic test_call_return();
    logic [18:0] e;
    cyc(2'b10, 8'h00, 8'h20, 1'b0, 1'b0);
    e = q.pop_front();
    cyc(2'b10, 8'h00, 8'h40, 1'b1, 1'b0);
    e = q.pop_front(); checks++;
    if (pc !== e[18:11] || ras_empty !== e[2]) begin
      $display("FAIL call: got pc=%h empty=%b, expected pc=%h empty=%b", pc, ras_empty, e[18:11], e[2]);
      failures++;
    end
    cyc(2'b11, 8'h00, 8'h99, 1'b0, 1'b0);
    e = q.pop_front(); checks++;
    if ({pc, pc_plus, ras_empty, ras_full, ras_err} !== e || pc !== 8'h21) begin
      $display("FAIL return: got pc=%h empty=%b err=%b, expected pc=%h efe=%b",
               pc, ras_empty, ras_err, e[18:11], e[2:0]);
      failures++;
    end
  endtask

  task automatic test_ras_bounds();
    logic [18:0] e;
    logic [7:0]  rets [5];
    rets = '{8'h42, 8'h32, 8'h22, 8'h12, 8'h13};
    cyc(2'b10, 8'h00, 8'h01, 1'b0, 1'b0);
    e = q.pop_front();
    for (int i = 0; i < 5; i++) begin
      cyc(2'b10, 8'h00, 8'h11 + 8'(i * 16), 1'b1, 1'b0);
      e = q.pop_front(); checks++;
      if ({pc, pc_plus, ras_empty, ras_full, ras_err} !== e) begin
        $display("FAIL push %0d: got pc=%h full=%b err=%b, expected pc=%h efe=%b",
                 i, pc, ras_full, ras_err, e[18:11], e[2:0]);
        failures++;
      end
    end
    checks++;
    if (ras_full !== 1'b1 || ras_err !== 1'b1) begin
      $display("FAIL overflow: got full=%b err=%b, expected full=1 err=1", ras_full, ras_err);
      failures++;
    end
    for (int i = 0; i < 5; i++) begin
      cyc(2'b11, 8'h00, 8'hAA, 1'b0, 1'b0);
      e = q.pop_front(); checks++;
      if ({pc, pc_plus, ras_empty, ras_full, ras_err} !== e || pc !== rets[i]) begin
        $display("FAIL pop %0d: got pc=%h empty=%b err=%b, expected pc=%h efe=%b",
                 i, pc, ras_empty, ras_err, e[18:11], e[2:0]);
        failures++;
      end
    end
  endtask

  task automatic test_async_reset();
    logic [18:0] e;
    cyc(2'b10, 8'h00, 8'h60, 1'b1, 1'b0);
    e = q.pop_front();
    cyc(2'b10, 8'h00, 8'h70, 1'b1, 1'b0);
    e = q.pop_front(); checks++;
    if ({pc, pc_plus, ras_empty, ras_full, ras_err} !== e) begin
      $display("FAIL pre_reset: got pc=%h empty=%b err=%b, expected pc=%h efe=%b",
               pc, ras_empty, ras_err, e[18:11], e[2:0]);
      failures++;
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (pc !== 8'h00 || ras_empty !== 1'b1 || ras_full !== 1'b0 || ras_err !== 1'b0) begin
      $display("FAIL async_reset: got pc=%h empty=%b full=%b err=%b, expected pc=00 empty=1 full=0 err=0",
               pc, ras_empty, ras_full, ras_err);
      failures++;
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cyc(2'b11, 8'h00, 8'h00, 1'b0, 1'b0);
    e = q.pop_front(); checks++;
    if ({pc, pc_plus, ras_empty, ras_full, ras_err} !== e) begin
      $display("FAIL post_reset: got pc=%h empty=%b err=%b, expected pc=%h efe=%b",
               pc, ras_empty, ras_err, e[18:11], e[2:0]);
      failures++;
    end
  endtask

  task automatic test_plain_jr();
    logic [18:0] e;
    cyc(2'b10, 8'h00, 8'h40, 1'b1, 1'b0);
    e = q.pop_front(); checks++;
    if ({pc, pc_plus, ras_empty, ras_full, ras_err} !== e || pc !== 8'h40) begin
      $display("FAIL jr_call: got pc=%h empty=%b err=%b, expected pc=%h efe=%b",
               pc, ras_empty, ras_err, e[18:11], e[2:0]);
      failures++;
    end
    cyc(2'b11, 8'h00, 8'h55, 1'b0, 1'b0);
    e = q.pop_front(); checks++;
    if ({pc, pc_plus, ras_empty, ras_full, ras_err} !== e || pc !== 8'h55) begin
      $display("FAIL jr_ret: got pc=%h empty=%b err=%b, expected pc=%h efe=%b",
               pc, ras_empty, ras_err, e[18:11], e[2:0]);
      failures++;
    end
  endtask

  initial begin
    test_reset();
    test_seq();
    test_branch_stall();
`ifdef PC_RAS_EN
    test_call_return();
    test_ras_bounds();
    test_async_reset();
`else
    test_plain_jr();
`endif
    checks++;
    if (q.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", q.size());
      failures++;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_unit_param.md
# pc_unit_param

Parametrised program-counter unit for the single-cycle MIPS datapath; it replaces the fixed 8-bit load-only program counter. It holds the current instruction address and computes the next one internally from sequential, branch, jump and return selections. It supports stall and an optional hardware return-address stack (RAS) for call/return. It sits between the control unit and the instruction memory address port.

## Interface
- WIDTH, 8: address width in bits.
- STEP, 1: per-instruction increment; 1 for word-addressed instruction memory, 4 for byte-addressed.
- RESET_VEC, 0: `pc` value after reset.
- RAS_DEPTH, 4: number of RAS entries; power of two, minimum 2.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold `pc` and RAS this cycle.
- sel  in  2  next-PC select: 00 sequential, 01 branch, 10 jump, 11 return.
- branch_off  in  WIDTH  two's-complement branch offset, already scaled.
- jump_target  in  WIDTH  absolute jump target, also the register target (jr).
- call  in  1  with sel=10, push the return address (jal).
- pc  out  WIDTH  current instruction address, registered.
- pc_plus  out  WIDTH  `pc + STEP`, combinational.
- ras_empty  out  1  RAS holds 0 entries.
- ras_full  out  1  RAS holds RAS_DEPTH entries.
- ras_err  out  1  sticky flag for RAS overflow or underflow.

## Operation
- All address arithmetic is modulo 2^WIDTH; wrap-around is silent.
- Next PC when stall=0:
  - sel=00: `pc + STEP`.
  - sel=01: `pc + STEP + branch_off`, MIPS delay-free form.
  - sel=10: `jump_target`. If call=1, also push `pc + STEP`.
  - sel=11: pop the RAS top and load it into `pc`.
- `call` is ignored unless sel=10.
- The RAS is circular, with a write pointer and a count of 0..RAS_DEPTH.
- Push when full: overwrite the oldest entry, keep count at RAS_DEPTH, set ras_err.
- Pop when empty: next PC is `pc + STEP`, count stays 0, ras_err is set.
- ras_err clears only on reset.
- stall=1: `pc`, RAS contents, count and ras_err all hold; sel and call are ignored. `pc_plus` still tracks `pc`.

## Timing
- `pc` and the RAS update on the rising clk edge only.
- `pc_plus`, ras_empty and ras_full are combinational from the registered state.
- The selected target appears on `pc` one cycle after it is presented.
- A pushed entry is poppable on the next cycle. A call followed immediately by a return returns to the caller's `pc + STEP`.
- Reset, asserted at any time including mid-stall:
  - `pc` = RESET_VEC.
  - RAS count = 0 and pointer = 0.
  - ras_empty = 1, ras_full = 0, ras_err = 0.
- The first non-reset edge after rst deasserts applies normal next-PC selection.

## Configuration
- `PC_RAS_EN` defined: RAS present as described above.
- `PC_RAS_EN` undefined:
  - No stack storage is built.
  - sel=11 loads `jump_target` (plain jr).
  - `call` is ignored.
  - ras_empty is tied to 1, ras_full to 0 and ras_err to 0.

## Test plan
All scenarios use WIDTH=8, STEP=1, RESET_VEC=0, RAS_DEPTH=4 and `PC_RAS_EN` defined unless stated.

1. Reset, then sel=00 for 3 cycles -> `pc` reads 0,1,2,3 and `pc_plus`=4. Repeat from `pc`=0xFE for 3 cycles -> `pc` reads 0xFF, 0x00, 0x01.
2. Branch and stall:
   - At `pc`=0x10, sel=01, branch_off=0xFC (-4) -> `pc`=0x0D.
   - Then stall=1 with sel=10, jump_target=0x80 for 2 cycles -> `pc` stays 0x0D.
3. Call/return:
   - At `pc`=0x20, sel=10, call=1, jump_target=0x40 -> `pc`=0x40, ras_empty=0.
   - Next cycle sel=11 -> `pc`=0x21, ras_empty=1, ras_err=0.
4. RAS boundaries:
   - 5 consecutive calls from `pc`=0x01,0x11,0x21,0x31,0x41, each jumping to the next address -> ras_full=1 and ras_err=1 after the 5th.
   - 4 returns -> `pc` = 0x42, 0x32, 0x22, 0x12.
   - A 5th return -> `pc` = `pc + 1`, ras_err stays 1.
5. Mid-operation reset: assert rst asynchronously between edges with 2 RAS entries and ras_err=1 -> `pc`=0, ras_empty=1 and ras_err=0 immediately, before the next edge.
6. `PC_RAS_EN` undefined: sel=10, call=1, jump_target=0x40, then sel=11 with jump_target=0x55 -> `pc`=0x40 then 0x55; ras_empty stays 1 and ras_err stays 0 throughout.
